// File: rtl/knn_pkg.sv
// Shared definitions for the KNN classifier: FSM states, list entry layout and
// default widths shared with the distance calculator.
package knn_pkg;

    localparam int KNN_W      = 16;
    localparam int KNN_TYPE_W = 3;
    localparam int KNN_K      = 7;
    localparam int KNN_CNT_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_VOTE,
        S_RESOLVE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                  occupied;
        logic [KNN_W-1:0]      distance;
        logic [KNN_TYPE_W-1:0] typ;
    } knn_entry_t;

endpackage

// File: rtl/knn_topk_list.sv
// K-entry ascending insertion list: one insert per cycle via parallel compare/shift,
// synchronous clear, and a combinational read port by index.
module knn_topk_list
    import knn_pkg::*;
#(
    parameter int K      = KNN_K,
    parameter int W      = KNN_W,
    parameter int TYPE_W = KNN_TYPE_W,
    parameter int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              insert,
    input  logic [W-1:0]      ins_distance,
    input  logic [TYPE_W-1:0] ins_type,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_occupied,
    output logic [W-1:0]      rd_distance,
    output logic [TYPE_W-1:0] rd_type
);

    typedef struct packed {
        logic              occupied;
        logic [W-1:0]      distance;
        logic [TYPE_W-1:0] typ;
    } entry_t;

    entry_t ent [K];
    entry_t nxt [K];
    entry_t new_e;
    entry_t prev;
    logic   after_cur;
    logic   prev_after;

    assign new_e = '{occupied: 1'b1, distance: ins_distance, typ: ins_type};

    // A slot is displaced when it is empty or strictly farther than the new sample,
    // so equal distances keep the earlier sample ahead.
    always_comb begin
        prev       = new_e;
        prev_after = 1'b0;
        after_cur  = 1'b0;
        for (int i = 0; i < K; i++) begin
            after_cur = !ent[i].occupied || (ent[i].distance > ins_distance);
            if (!after_cur)
                nxt[i] = ent[i];
            else if (prev_after)
                nxt[i] = prev;
            else
                nxt[i] = new_e;
            prev       = ent[i];
            prev_after = after_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < K; i++)
                ent[i] <= '{occupied: 1'b0, distance: {W{1'b1}}, typ: '0};
        end else if (insert) begin
            for (int i = 0; i < K; i++)
                ent[i] <= nxt[i];
        end
    end

    assign rd_occupied = ent[rd_idx].occupied;
    assign rd_distance = ent[rd_idx].distance;
    assign rd_type     = ent[rd_idx].typ;

endmodule

// File: rtl/knn_topk_voter.sv
// Streaming K-nearest-neighbour classifier: collects a programmable number of
// samples into a top-K list, then votes with a nearest-neighbour tie-break.
module knn_topk_voter
    import knn_pkg::*;
#(
    parameter int W      = KNN_W,
    parameter int TYPE_W = KNN_TYPE_W,
    parameter int K      = KNN_K,
    parameter int CNT_W  = KNN_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic                   dist_valid,
    output logic                   dist_ready,
    input  logic [W-1:0]           distance,
    input  logic [TYPE_W-1:0]      dist_type,
    output logic                   busy,
    output logic                   result_valid,
    output logic [TYPE_W-1:0]      inferred_type,
    output logic [$clog2(K+1)-1:0] vote_count,
    output logic [W-1:0]           min_distance,
    output logic                   error
);

    localparam int NUM_TYPES = 1 << TYPE_W;
    localparam int HW        = $clog2(K + 1);
    localparam int IDX_W     = (K > 1) ? $clog2(K) : 1;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, target;
    logic [IDX_W-1:0]    vidx;
    logic [HW-1:0]       hist      [NUM_TYPES];
    logic [IDX_W-1:0]    first_idx [NUM_TYPES];
    logic [NUM_TYPES-1:0] seen;

    logic                launch, accept, last_sample, last_vote;
    logic                rd_occ;
    logic [W-1:0]        rd_dist;
    logic [TYPE_W-1:0]   rd_type;

    logic [TYPE_W-1:0]   best_type;
    logic [HW-1:0]       best_cnt;
    logic [IDX_W-1:0]    best_first;
    logic                have;

    assign accept      = dist_valid && dist_ready;
    assign last_sample = (cnt == target - CNT_W'(1));
    assign last_vote   = (vidx == IDX_W'(K - 1));

    knn_topk_list #(.K(K), .W(W), .TYPE_W(TYPE_W), .IDX_W(IDX_W)) u_list (
        .clk          (clk),
        .rst          (rst),
        .clear        (launch),
        .insert       (accept),
        .ins_distance (distance),
        .ins_type     (dist_type),
        .rd_idx       (vidx),
        .rd_occupied  (rd_occ),
        .rd_distance  (rd_dist),
        .rd_type      (rd_type)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dist_ready = 1'b0;
        busy       = 1'b0;
        launch     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = (num_samples == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                dist_ready = 1'b1;
                busy       = 1'b1;
                if (dist_valid && last_sample) state_nxt = S_VOTE;
            end
            S_VOTE: begin
                busy = 1'b1;
                if (last_vote) state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Highest count wins; equal counts go to the type that owns the nearer entry.
    always_comb begin
        best_type  = '0;
        best_cnt   = '0;
        best_first = '0;
        have       = 1'b0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (hist[t] != '0 && (!have || hist[t] > best_cnt ||
                (hist[t] == best_cnt && first_idx[t] < best_first))) begin
                have       = 1'b1;
                best_type  = TYPE_W'(t);
                best_cnt   = hist[t];
                best_first = first_idx[t];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            target        <= '0;
            vidx          <= '0;
            seen          <= '0;
            result_valid  <= 1'b0;
            inferred_type <= '0;
            vote_count    <= '0;
            min_distance  <= '0;
            error         <= 1'b0;
            for (int t = 0; t < NUM_TYPES; t++) begin
                hist[t]      <= '0;
                first_idx[t] <= '0;
            end
        end else begin
            if (launch) begin
                target       <= num_samples;
                cnt          <= '0;
                vidx         <= '0;
                seen         <= '0;
                result_valid <= 1'b0;
                error        <= 1'b0;
                for (int t = 0; t < NUM_TYPES; t++) hist[t] <= '0;
                if (num_samples == '0) begin
                    result_valid  <= 1'b1;
                    error         <= 1'b1;
                    inferred_type <= '0;
                    vote_count    <= '0;
                    min_distance  <= {W{1'b1}};
                end
            end
            if (accept) cnt <= cnt + CNT_W'(1);
            if (state == S_VOTE) begin
                // Wrap to 0 so RESOLVE reads the head entry through the same port.
                vidx <= last_vote ? '0 : vidx + IDX_W'(1);
                if (rd_occ) begin
                    hist[rd_type] <= hist[rd_type] + HW'(1);
                    if (!seen[rd_type]) begin
                        seen[rd_type]      <= 1'b1;
                        first_idx[rd_type] <= vidx;
                    end
                end
            end
            if (state == S_RESOLVE) begin
                inferred_type <= best_type;
                vote_count    <= best_cnt;
                min_distance  <= rd_dist;
                error         <= 1'b0;
                result_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/knn_topk_voter.md
# knn_topk_voter

Streaming K-nearest-neighbour classifier core. It accepts one distance/type pair per cycle from the distance calculator and keeps only the K smallest in a sorted insertion list. After a runtime-programmable number of samples it runs a sequential majority vote with a nearest-neighbour tie-break. It replaces the fixed 2^L collect-then-sort path: no padding to a power of two, and the sample count is chosen per query.

## Interface
- W, 16, distance width
- TYPE_W, 3, class label width; NUM_TYPES = 2^TYPE_W
- K, 7, neighbours kept and voted (K ≥ 1)
- CNT_W, 10, sample-counter width; max samples per query 2^CNT_W−1
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a query, captures num_samples
- num_samples  in  CNT_W  training samples in this query
- dist_valid  in  1  distance/type pair valid
- dist_ready  out  1  core accepts a pair this cycle
- distance  in  W  distance of current sample
- dist_type  in  TYPE_W  label of current sample
- busy  out  1  query in progress (COLLECT/VOTE/RESOLVE)
- result_valid  out  1  result held valid until next start or rst
- inferred_type  out  TYPE_W  winning label
- vote_count  out  $clog2(K+1)  votes for winning label
- min_distance  out  W  smallest distance seen
- error  out  1  query had num_samples = 0

## Operation
- States: IDLE, COLLECT, VOTE, RESOLVE, DONE.
- IDLE/DONE + start:
  - capture num_samples;
  - clear all K list entries: occupied=0, distance=all-ones;
  - clear result_valid;
  - go to COLLECT, or straight to DONE if num_samples=0.
- num_samples=0: DONE with result_valid=1, error=1, inferred_type=0, vote_count=0, min_distance=all-ones.
- COLLECT:
  - dist_ready=1; a pair is accepted when dist_valid && dist_ready.
  - Each accepted pair is inserted in one cycle with a parallel compare/shift into an ascending list.
  - A new entry goes after existing entries of equal distance (stable: the earlier sample wins).
  - The entry at index K−1 drops off when the list is full.
  - An all-ones distance is a legal value; the occupied bits separate real entries from empty ones.
  - After the num_samples-th accepted pair, go to VOTE.
- VOTE: K cycles, index j = 0..K−1. If entry j is occupied:
  - increment hist[type];
  - record first_idx[type] = j if this is the type's first hit.
- RESOLVE:
  - winner = type with maximum hist;
  - ties go to the smallest first_idx (the type owning the nearest neighbour).
  - Register inferred_type, vote_count, min_distance = entry 0 distance, error=0; go to DONE.
- DONE: result_valid=1 and outputs held.
- start while busy is ignored. dist_valid outside COLLECT is ignored (dist_ready=0).
- Counters saturate at no point: the sample count compares for equality with num_samples. Histogram width is $clog2(K+1).

## Timing
- Reset values: dist_ready=0, busy=0, result_valid=0, inferred_type=0, vote_count=0, min_distance=0, error=0, state IDLE.
- rst in any state aborts the query on the next edge. List, histogram and counters are cleared.
- Edge accepting start → COLLECT on the next cycle; dist_ready is high from that cycle.
- Throughput: one sample per cycle, no bubbles.
- Edge accepting the last sample → result_valid rises K+1 cycles later (K VOTE cycles + RESOLVE).
- num_samples=0: result_valid is high the cycle after the start edge.
- start in DONE drops result_valid on the next cycle; a new result never aliases an old one.

## Structure
- Shared package knn_pkg holds:
  - state enum;
  - list entry struct {occupied, distance[W], type[TYPE_W]};
  - default parameter constants shared with the distance calculator.
- One sub-module, knn_topk_list: K-entry sorted insertion list with clear, insert, and read port by index.
- The FSM, histogram and resolve logic stay in knn_topk_voter.

## Test plan
Defaults apply: K=7, W=16, TYPE_W=3.
- 10 samples, distances 50,10,40,20,60,30,70,5,80,90, types 1,2,2,2,3,3,1,1,4,4 → inferred_type=2, vote_count=3, min_distance=5, error=0.
- num_samples=4, (8,t3),(3,t5),(9,t5),(2,t3) → 2–2 tie broken by nearest → inferred_type=3, vote_count=2, min_distance=2.
- num_samples=8, all distance 7, types 0..7 → type 7 evicted (stable insertion); inferred_type=0, vote_count=1.
- start with num_samples=0 → result_valid=1 next cycle, error=1, vote_count=0.
- Random dist_valid gaps, plus start pulsed mid-COLLECT → start ignored, same result as the gap-free run. result_valid rises exactly K+1 cycles after the last accept. dist_ready is low outside COLLECT.
- rst asserted mid-COLLECT, then a fresh query of scenario 1 → identical result with no residue from the aborted query.
